// File: rtl/hadamard_pkg.sv
// Shared definitions for the Hadamard product pipeline: limits, the
// wide lane-product type and the per-lane saturate/reduce helper.
package hadamard_pkg;

    localparam int LATENCY_MAX = 4;
    localparam int WIDTH_MAX   = 64;

    // Lane product at the widest supported element width. A lane of width W
    // sign- or zero-extends its 2*W product into this type before reducing.
    typedef logic [2*WIDTH_MAX-1:0] prod_t;

    typedef struct packed {
        logic                 ovf;
        logic [WIDTH_MAX-1:0] res;
    } reduce_t;

    // Reduce a full-width product to 'width' bits. Overflow is reported in
    // both modes; sat_mode selects clamping versus keeping the low bits.
    function automatic reduce_t sat_reduce(input prod_t p, input int width,
                                           input logic signed_mode,
                                           input logic sat_mode);
        prod_t   hi;
        prod_t   lo;
        logic    over;
        logic    under;
        reduce_t r;
        if (signed_mode) begin
            hi    = (prod_t'(1) << (width - 1)) - prod_t'(1);
            lo    = ~hi;
            over  = $signed(p) > $signed(hi);
            under = $signed(p) < $signed(lo);
        end else begin
            hi    = (prod_t'(1) << width) - prod_t'(1);
            lo    = '0;
            over  = p > hi;
            under = 1'b0;
        end
        r.ovf = over | under;
        if (sat_mode && over) begin
            r.res = hi[WIDTH_MAX-1:0];
        end else if (sat_mode && under) begin
            r.res = lo[WIDTH_MAX-1:0];
        end else begin
            r.res = p[WIDTH_MAX-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/hadamard_pipe_unit_lane.sv
// One multiplier lane: multiply, optional delay stages, saturate/reduce.
// Holds only data registers; the load enables come from the top level.
module hadamard_lane
    import hadamard_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter bit SIGNED  = 1'b1,
    parameter bit SAT     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LATENCY-1:0] ld,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   res,
    output logic               ovf
);

    typedef logic [2*WIDTH-1:0] lane_prod_t;

    lane_prod_t ext_a;
    lane_prod_t ext_b;
    lane_prod_t prod;
    lane_prod_t red_src;
    prod_t      red_in;
    reduce_t    red;

    // Full 2*WIDTH product; the low 2*WIDTH bits of the extended operands'
    // product are exact in both signed and unsigned mode.
    always_comb begin
        if (SIGNED) begin
            ext_a = {{WIDTH{a[WIDTH-1]}}, a};
            ext_b = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            ext_a = {{WIDTH{1'b0}}, a};
            ext_b = {{WIDTH{1'b0}}, b};
        end
        prod = ext_a * ext_b;
    end

    if (LATENCY == 1) begin : g_single
        assign red_src = prod;
    end else begin : g_multi
        lane_prod_t pipe [LATENCY-1];

        // Stage 0 captures the product; further stages are pure delay.
        // NOTE: pipeline data is reset too, so nothing stale is ever visible.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < LATENCY - 1; s++) pipe[s] <= '0;
            end else begin
                if (ld[0]) pipe[0] <= prod;
                for (int s = 1; s < LATENCY - 1; s++) begin
                    if (ld[s]) pipe[s] <= pipe[s-1];
                end
            end
        end

        assign red_src = pipe[LATENCY-2];
    end

    // Extend the lane product to the package width and reduce it.
    always_comb begin
        if (SIGNED) red_in = prod_t'($signed(red_src));
        else        red_in = prod_t'(red_src);
        red = sat_reduce(red_in, WIDTH, SIGNED, SAT);
    end

    // Last stage registers the WIDTH-bit result and its overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
            ovf <= 1'b0;
        end else if (ld[LATENCY-1]) begin
            res <= red.res[WIDTH-1:0];
            ovf <= red.ovf;
        end
    end

endmodule

// File: rtl/hadamard_pipe_unit.sv
// Flow-controlled, pipelined element-wise product of kernel and patch.
// Owns the stage valid bits and ready chain; lanes only see load enables.
module hadamard_pipe_unit
    import hadamard_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 9,
    parameter int LATENCY = 2,
    parameter bit SIGNED  = 1'b1,
    parameter bit SAT     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIZE-1:0][WIDTH-1:0] kernel,
    input  logic [SIZE-1:0][WIDTH-1:0] patch,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIZE-1:0][WIDTH-1:0] res,
    output logic [SIZE-1:0]            ovf
);

    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] rdy;
    logic [LATENCY-1:0] ld;

    // Stage s may load unless it and every stage ahead are full while the
    // output stalls; load enables follow from the upstream valid.
    always_comb begin : ready_chain
        logic full_tail;
        // NOTE: every combinational output gets a default first, so no latch.
        full_tail = 1'b1;
        rdy       = '0;
        ld        = '0;
        for (int s = LATENCY - 1; s >= 0; s--) begin
            full_tail = full_tail & v[s];
            rdy[s]    = out_ready | ~full_tail;
        end
        ld[0] = rdy[0] & in_valid;
        for (int s = 1; s < LATENCY; s++) begin
            ld[s] = rdy[s] & v[s-1];
        end
    end

    // Stage valid bits advance whenever their stage may load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples pre-edge neighbours.
            if (rdy[0]) v[0] <= in_valid;
            for (int s = 1; s < LATENCY; s++) begin
                if (rdy[s]) v[s] <= v[s-1];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[LATENCY-1];

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        hadamard_lane #(
            .WIDTH  (WIDTH),
            .LATENCY(LATENCY),
            .SIGNED (SIGNED),
            .SAT    (SAT)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .ld   (ld),
            .a    (kernel[i]),
            .b    (patch[i]),
            .res  (res[i]),
            .ovf  (ovf[i])
        );
    end

endmodule

// File: tb/tb_hadamard_pipe_unit.sv
// Scoreboard bench: four configurations of the unit (WIDTH=8, SIZE=4).
// Accepted inputs push a reference result; monitors pop and compare.
module tb_hadamard_pipe_unit;

    localparam int N = 4;
    // inst0: L2 signed sat, inst1: L3 signed sat,
    // inst2: L1 unsigned wrap, inst3: L4 unsigned sat
    localparam int LAT [N] = '{2, 3, 1, 4};
    localparam bit SGN [N] = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam bit STA [N] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic            clk;
    logic            rst_n;
    logic            in_valid  [N];
    logic            in_ready  [N];
    logic [3:0][7:0] kernel    [N];
    logic [3:0][7:0] patch     [N];
    logic            out_valid [N];
    logic            out_ready [N];
    logic [3:0][7:0] res       [N];
    logic [3:0]      ovf       [N];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          outstanding [N];
    bit          lat_chk [N];
    logic [35:0] last_out [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int g,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)",
                     name, g, act, exp, cyc);
        end
    endtask

    // Reference: plain integer product, range test, clamp or wrap.
    function automatic logic [35:0] model(input logic [31:0] k,
                                          input logic [31:0] p,
                                          input bit sgn, input bit sat);
        logic [31:0] r_all;
        logic [3:0]  o_all;
        for (int i = 0; i < 4; i++) begin
            int a, b, prod, lo, hi, r;
            if (sgn) begin
                a = int'($signed(k[i*8 +: 8]));
                b = int'($signed(p[i*8 +: 8]));
                lo = -128; hi = 127;
            end else begin
                a = int'(k[i*8 +: 8]);
                b = int'(p[i*8 +: 8]);
                lo = 0; hi = 255;
            end
            prod = a * b;
            o_all[i] = (prod < lo) || (prod > hi);
            if (sat && prod > hi)      r = hi;
            else if (sat && prod < lo) r = lo;
            else                       r = prod;
            r_all[i*8 +: 8] = r[7:0];
        end
        return {o_all, r_all};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        hadamard_pipe_unit #(
            .WIDTH  (8),
            .SIZE   (4),
            .LATENCY(LAT[g]),
            .SIGNED (SGN[g]),
            .SAT    (STA[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .kernel   (kernel[g]),
            .patch    (patch[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .res      (res[g]),
            .ovf      (ovf[g])
        );

        logic [35:0] exp_q [$];
        int          cyc_q [$];

        // Monitor: samples on the falling edge what the next rising edge transfers.
        initial begin
            logic [35:0] held;
            logic [35:0] got;
            bit          stalled;
            stalled = 1'b0;
            held    = '0;
            outstanding[g] = 0;
            forever begin
                @(negedge clk);
                got = {ovf[g], res[g]};
                if (!rst_n) begin
                    exp_q.delete();
                    cyc_q.delete();
                    outstanding[g] = 0;
                    stalled = 1'b0;
                end else begin
                    if (stalled) begin
                        check("stall_valid_held", g, 64'(out_valid[g]), 64'd1);
                        check("stall_data_held", g, 64'(got), 64'(held));
                    end
                    if (out_valid[g] && out_ready[g]) begin
                        check("output_expected", g, 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) begin
                            int c0;
                            check("data", g, 64'(got), 64'(exp_q.pop_front()));
                            c0 = cyc_q.pop_front();
                            if (lat_chk[g]) check("latency", g, 64'(cyc - c0), 64'(LAT[g]));
                            outstanding[g]--;
                        end
                        last_out[g] = got;
                    end
                    if (in_valid[g] && in_ready[g]) begin
                        exp_q.push_back(model(kernel[g], patch[g], SGN[g], STA[g]));
                        cyc_q.push_back(cyc);
                        outstanding[g]++;
                    end
                    stalled = out_valid[g] && !out_ready[g];
                    held    = got;
                end
            end
        end
    end

    task automatic send(input int g, input logic [31:0] k, input logic [31:0] p);
        bit acc;
        int t;
        @(posedge clk); #1;
        in_valid[g] = 1'b1;
        kernel[g]   = k;
        patch[g]    = p;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = in_ready[g];
            if (!acc) begin
                @(posedge clk); #1;
            end
            t++;
        end
        if (!acc) check("send_timeout", g, 64'(acc), 64'd1);
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_drain();
        int total;
        for (int t = 0; t < 300; t++) begin
            total = 0;
            for (int g = 0; g < N; g++) total += outstanding[g];
            if (total == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        for (int g = 0; g < N; g++) check("drained", g, 64'(outstanding[g]), 64'd0);
    endtask

    task automatic random_run(input int g, input int n);
        bit pending;
        pending = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (!pending) begin
                in_valid[g] = 1'($urandom_range(0, 1));
                kernel[g]   = $urandom;
                patch[g]    = $urandom;
            end
            out_ready[g] = 1'($urandom_range(0, 1));
            @(negedge clk);
            pending = in_valid[g] && !in_ready[g];
        end
        @(posedge clk); #1;
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b1;
    endtask

    initial begin
        int sent;
        rst_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            in_valid[g] = 1'b0; out_ready[g] = 1'b0;
            kernel[g] = '0; patch[g] = '0; lat_chk[g] = 1'b0;
        end
        #12;
        for (int g = 0; g < N; g++) begin
            check("reset_out_valid", g, 64'(out_valid[g]), 64'd0);
            check("reset_res_ovf", g, 64'({ovf[g], res[g]}), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < N; g++) check("ready_after_reset", g, 64'(in_ready[g]), 64'd1);

        // Reset mid-stream: two vectors stuck in inst1, then reset.
        send(1, {4{8'd5}}, {4{8'd7}});
        send(1, {4{8'd6}}, {4{8'd7}});
        repeat (3) @(posedge clk);
        #1;
        check("stalled_before_reset", 1, 64'(out_valid[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 1, 64'(out_valid[1]), 64'd0);
        check("midreset_res_ovf", 1, 64'({ovf[1], res[1]}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready[1] = 1'b1;
        #1;
        check("ready_after_midreset", 1, 64'(in_ready[1]), 64'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("nothing_after_reset", 1, 64'(out_valid[1]), 64'd0);

        // Streaming on inst0: 3 * -5 every cycle, latency checked.
        lat_chk[0]   = 1'b1;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid[0] = 1'b1;
            kernel[0]   = {4{8'd3}};
            patch[0]    = {4{8'hFB}};
            @(negedge clk);
            check("stream_in_ready", 0, 64'(in_ready[0]), 64'd1);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_drain();
        lat_chk[0] = 1'b0;
        check("stream_value", 0, 64'(last_out[0]), 64'({4'h0, {4{8'hF1}}}));

        // Signed saturation: 100*2, -128*-128, -128*1, 127*127.
        send(0, {8'd127, 8'h80, 8'h80, 8'd100}, {8'd127, 8'd1, 8'h80, 8'd2});
        wait_drain();
        check("signed_sat", 0, 64'(last_out[0]), 64'({4'b1011, 8'h7F, 8'h80, 8'h7F, 8'h7F}));

        // Unsigned wrap and unsigned saturation around 255.
        out_ready[2] = 1'b1;
        out_ready[3] = 1'b1;
        send(2, {4{8'd200}}, {4{8'd3}});
        send(3, {8'd0, 8'd16, 8'd15, 8'd200}, {8'd255, 8'd16, 8'd17, 8'd3});
        wait_drain();
        check("unsigned_wrap", 2, 64'(last_out[2]), 64'({4'hF, {4{8'h58}}}));
        check("unsigned_sat", 3, 64'(last_out[3]), 64'({4'b0101, 8'h00, 8'hFF, 8'hFF, 8'hFF}));

        // Backpressure on inst1 (LATENCY=3): stall cycles 2..9.
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready[1] = !(c >= 2 && c <= 9);
            if (sent < 6) begin
                in_valid[1] = 1'b1;
                kernel[1]   = {4{8'(sent + 1)}};
                patch[1]    = {4{8'd1}};
            end else begin
                in_valid[1] = 1'b0;
            end
            @(negedge clk);
            if (c == 5) begin
                check("bp_in_ready_low", 1, 64'(in_ready[1]), 64'd0);
                check("bp_accepts", 1, 64'(sent), 64'd3);
            end
            if (in_valid[1] && in_ready[1]) sent++;
        end
        check("bp_all_sent", 1, 64'(sent), 64'd6);
        wait_drain();
        check("bp_last_tag", 1, 64'(last_out[1]), 64'({4'h0, {4{8'd6}}}));

        // Random bubbles and backpressure on all configurations.
        fork
            random_run(0, 1000);
            random_run(1, 1000);
            random_run(2, 1000);
            random_run(3, 1000);
        join
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
